// File: rtl/oled_i2c_pkg.sv
// rtl/oled_i2c_pkg.sv - shared state, quarter and slot constants for the OLED I2C master
package oled_i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    ACK,
    STOP,
    HOLD
  } state_t;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam int DATA_SLOTS = 8;
  localparam int ACK_SLOTS  = 1;

endpackage

// File: rtl/oled_i2c_qtick.sv
// rtl/oled_i2c_qtick.sv - SCL quarter-period tick and quarter index generator
module oled_i2c_qtick
  import oled_i2c_pkg::*;
#(
  parameter int CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic       tick,
  output logic [1:0] quarter
);

  logic [15:0] cnt;

  assign tick = en && !clr && (cnt == 16'(CLK_DIV - 1));

  // Divide the clock into quarters; the index wraps naturally after Q3.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt     <= '0;
      quarter <= Q0;
    end else if (en) begin
      if (tick) begin
        cnt     <= '0;
        quarter <= quarter + 2'd1;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/oled_i2c_master.sv
// rtl/oled_i2c_master.sv - single-byte I2C write master for an OLED panel
module oled_i2c_master
  import oled_i2c_pkg::*;
#(
  parameter int CLK_DIV = 125
) (
  input  logic       CLOCK,
  input  logic       RST,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_start,
  input  logic       cmd_stop,
  input  logic [7:0] cmd_data,
  output logic       done,
  output logic       nack,
  output logic       busy,
  output logic       OLED_SCL,
  inout  wire        OLED_SDA
);

  state_t      state, state_n;
  logic [2:0]  slot, slot_n;
  logic [7:0]  data_r, data_n;
  logic [1:0]  q_n;
  logic        stop_r;
  logic        scl_r, scl_n;
  logic        sda_low_r, sda_low_n;
  logic        busy_r, ready_r, done_r, nack_r, done_n;
  logic        tick, last_q, accept, running;
  logic [1:0]  quarter;

  assign accept  = cmd_valid && ready_r;
  assign running = (state != IDLE) && (state != HOLD);
  assign last_q  = tick && (quarter == Q3);

  oled_i2c_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
    .clk     (CLOCK),
    .rst     (RST),
    .clr     (accept),
    .en      (running),
    .tick    (tick),
    .quarter (quarter)
  );

  // Next state, then the bus levels for the state/quarter the next cycle will be in.
  always_comb begin
    state_n   = state;
    slot_n    = slot;
    done_n    = 1'b0;
    data_n    = accept ? cmd_data : data_r;
    q_n       = accept ? Q0 : (tick ? quarter + 2'd1 : quarter);
    scl_n     = scl_r;
    sda_low_n = 1'b0;

    case (state)
      IDLE: if (accept) begin
        state_n = START;
        slot_n  = '0;
      end
      HOLD: if (accept) begin
        state_n = cmd_start ? START : DATA;
        slot_n  = '0;
      end
      START: if (last_q) state_n = DATA;
      DATA: if (last_q) begin
        if (slot == 3'(DATA_SLOTS - 1)) begin
          state_n = ACK;
          slot_n  = '0;
        end else begin
          slot_n = slot + 3'd1;
        end
      end
      ACK: if (last_q) begin
        if (slot == 3'(ACK_SLOTS - 1)) begin
          state_n = stop_r ? STOP : HOLD;
          done_n  = !stop_r;
          slot_n  = '0;
        end else begin
          slot_n = slot + 3'd1;
        end
      end
      STOP: if (last_q) begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase

    case (state_n)
      IDLE: scl_n = 1'b1;
      START: begin
        case (q_n)
          Q0: scl_n = scl_r;
          Q1: scl_n = 1'b1;
          Q2: begin
            scl_n     = 1'b1;
            sda_low_n = 1'b1;
          end
          default: begin
            scl_n     = 1'b0;
            sda_low_n = 1'b1;
          end
        endcase
      end
      DATA: begin
        scl_n     = q_n[1];
        sda_low_n = !data_n[3'(DATA_SLOTS - 1) - slot_n];
      end
      ACK: scl_n = q_n[1];
      STOP: begin
        scl_n     = q_n[1];
        sda_low_n = (q_n != Q3);
      end
      HOLD: begin
        scl_n     = 1'b0;
        sda_low_n = 1'b1;
      end
      default: scl_n = 1'b1;
    endcase
  end

  // State and registered outputs; the ACK bit is captured on the last cycle of Q2.
  always_ff @(posedge CLOCK) begin
    if (RST) begin
      state     <= IDLE;
      slot      <= '0;
      data_r    <= '0;
      stop_r    <= 1'b0;
      scl_r     <= 1'b1;
      sda_low_r <= 1'b0;
      busy_r    <= 1'b0;
      ready_r   <= 1'b1;
      done_r    <= 1'b0;
      nack_r    <= 1'b0;
    end else begin
      state     <= state_n;
      slot      <= slot_n;
      data_r    <= data_n;
      scl_r     <= scl_n;
      sda_low_r <= sda_low_n;
      done_r    <= done_n;
      busy_r    <= (state_n != IDLE) && (state_n != HOLD);
      ready_r   <= (state_n == IDLE) || (state_n == HOLD);
      if (accept) stop_r <= cmd_stop;
      if (state == ACK && tick && quarter == Q2) nack_r <= OLED_SDA;
    end
  end

  assign OLED_SCL  = scl_r;
  assign OLED_SDA  = sda_low_r ? 1'b0 : 1'bz;
  assign cmd_ready = ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign nack      = nack_r;

endmodule

// File: tb/tb_oled_i2c_master.sv
// tb/tb_oled_i2c_master.sv - self-checking bench for oled_i2c_master
module tb_oled_i2c_master;

  localparam int D = 2;

  logic       CLOCK = 1'b0;
  logic       RST = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_start = 1'b0;
  logic       cmd_stop = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready, done, nack, busy, OLED_SCL;
  wire        sda;

  logic       slave_drive = 1'b0;
  logic       slave_nack = 1'b0;

  pullup (sda);
  assign sda = slave_drive ? 1'b0 : 1'bz;

  oled_i2c_master #(.CLK_DIV(D)) dut (
    .CLOCK     (CLOCK),
    .RST       (RST),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_start (cmd_start),
    .cmd_stop  (cmd_stop),
    .cmd_data  (cmd_data),
    .done      (done),
    .nack      (nack),
    .busy      (busy),
    .OLED_SCL  (OLED_SCL),
    .OLED_SDA  (sda)
  );

  always #5 CLOCK = ~CLOCK;

  int checks = 0;
  int failures = 0;
  bit model_idle = 1'b1;

  // Bus monitor and slave: counts START/STOP conditions, shifts bits on SCL rise,
  // drives the ACK slot and collects received bytes.
  int         starts = 0;
  int         stops = 0;
  int         scnt = 0;
  logic [7:0] shreg = 8'h00;
  logic [7:0] rx_q[$];
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;

  always @(negedge CLOCK) begin
    if (prev_scl && OLED_SCL && prev_sda && !sda) begin
      starts++;
      scnt = 0;
      shreg = 8'h00;
    end else if (prev_scl && OLED_SCL && !prev_sda && sda) begin
      stops++;
      scnt = 0;
    end else if (!prev_scl && OLED_SCL) begin
      if (scnt < 8) begin
        shreg = {shreg[6:0], sda};
        scnt++;
      end else if (scnt == 8) begin
        scnt = 9;
      end
    end else if (prev_scl && !OLED_SCL) begin
      if (scnt == 8) begin
        slave_drive = !slave_nack;
      end else if (scnt == 9) begin
        slave_drive = 1'b0;
        scnt = 0;
        rx_q.push_back(shreg);
      end
    end
    prev_scl = OLED_SCL;
    prev_sda = sda;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Cycles from accept to done: optional START, eight data slots, ACK, optional STOP.
  function automatic int model_lat(input bit eff_start, input bit sp);
    return D * (4 * int'(eff_start) + 4 * 8 + 4 + 4 * int'(sp));
  endfunction

  task automatic run_cmd(input bit st, input bit sp, input logic [7:0] d, input bit sn,
                         input bit hv, input int exp_lat, input bit exp_nack,
                         input int exp_starts, input string tag);
    int s0, p0, r0, k, hs_bad;
    bit seen;
    logic [31:0] last;
    slave_nack = sn;
    s0 = starts;
    p0 = stops;
    r0 = rx_q.size();
    check({tag, " ready_before"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_start = st;
    cmd_stop  = sp;
    cmd_data  = d;
    @(posedge CLOCK); #1;
    if (!hv) cmd_valid = 1'b0;
    k = 0;
    seen = 1'b0;
    hs_bad = 0;
    while (!seen && k < 60 * D + 20) begin
      if (busy !== 1'b1 || cmd_ready !== 1'b0) hs_bad++;
      @(posedge CLOCK); #1;
      k++;
      if (done === 1'b1) seen = 1'b1;
    end
    cmd_valid = 1'b0;
    check({tag, " done_seen"}, seen, 1);
    check({tag, " latency"}, k, exp_lat);
    check({tag, " nack"}, nack, exp_nack);
    check({tag, " busy_at_done"}, busy, 0);
    check({tag, " handshake_while_busy"}, hs_bad, 0);
    @(posedge CLOCK); #1;
    check({tag, " done_one_cycle"}, done, 0);
    last = (rx_q.size() > r0) ? {24'h0, rx_q[rx_q.size() - 1]} : 32'hFFFF_FFFF;
    check({tag, " bytes_sent"}, rx_q.size() - r0, 1);
    check({tag, " byte"}, last, {24'h0, d});
    check({tag, " starts"}, starts - s0, exp_starts);
    check({tag, " stops"}, stops - p0, {31'h0, sp});
    check({tag, " scl_after"}, OLED_SCL, {31'h0, sp});
    check({tag, " sda_after"}, sda, {31'h0, sp});
    model_idle = sp;
  endtask

  typedef struct {
    bit         st;
    bit         sp;
    logic [7:0] d;
    bit         sn;
    bit         hv;
    int         lat;
    bit         enack;
    int         estarts;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{1'b1, 1'b1, 8'h78, 1'b0, 1'b0, 88, 1'b0, 1};
    tbl[1] = '{1'b1, 1'b1, 8'hAE, 1'b1, 1'b1, 88, 1'b1, 1};
    tbl[2] = '{1'b1, 1'b0, 8'h78, 1'b0, 1'b0, 80, 1'b0, 1};
    tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 72, 1'b0, 0};
    tbl[4] = '{1'b0, 1'b1, 8'hAF, 1'b0, 1'b0, 80, 1'b0, 0};
    tbl[5] = '{1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 80, 1'b1, 1};
    tbl[6] = '{1'b1, 1'b1, 8'h5A, 1'b0, 1'b1, 88, 1'b0, 1};

    repeat (3) @(posedge CLOCK);
    #1;
    check("reset scl", OLED_SCL, 1);
    check("reset sda", sda, 1);
    check("reset done", done, 0);
    check("reset nack", nack, 0);
    check("reset busy", busy, 0);
    check("reset ready", cmd_ready, 1);
    RST = 1'b0;
    @(posedge CLOCK); #1;
    check("post reset ready", cmd_ready, 1);

    for (int i = 0; i < 7; i++) begin
      run_cmd(tbl[i].st, tbl[i].sp, tbl[i].d, tbl[i].sn, tbl[i].hv,
              tbl[i].lat, tbl[i].enack, tbl[i].estarts, $sformatf("vec%0d", i));
      repeat ($urandom_range(0, 3)) @(posedge CLOCK);
      #1;
    end

    for (int i = 0; i < 24; i++) begin
      bit st, sp, sn, hv, eff;
      logic [7:0] d;
      st  = 1'($urandom);
      sp  = 1'($urandom);
      sn  = 1'($urandom);
      hv  = 1'($urandom);
      d   = 8'($urandom);
      eff = model_idle | st;
      run_cmd(st, sp, d, sn, hv, model_lat(eff, sp), sn, int'(eff), $sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 4)) @(posedge CLOCK);
      #1;
      if (!model_idle) check($sformatf("rnd%0d hold_scl", i), OLED_SCL, 0);
    end

    // Reset in the middle of bit 3 of a START+STOP byte.
    begin
      int dcount;
      if (!model_idle) begin
        run_cmd(1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, model_lat(1'b0, 1'b1), 1'b0, 0, "close");
      end
      slave_nack = 1'b0;
      cmd_valid = 1'b1;
      cmd_start = 1'b1;
      cmd_stop  = 1'b1;
      cmd_data  = 8'h78;
      @(posedge CLOCK); #1;
      cmd_valid = 1'b0;
      repeat (21 * D) @(posedge CLOCK);
      #1;
      check("midreset busy_before", busy, 1);
      RST = 1'b1;
      @(posedge CLOCK); #1;
      RST = 1'b0;
      check("midreset scl", OLED_SCL, 1);
      check("midreset sda", sda, 1);
      check("midreset ready", cmd_ready, 1);
      check("midreset busy", busy, 0);
      check("midreset done", done, 0);
      dcount = 0;
      repeat (100) begin
        @(posedge CLOCK); #1;
        if (done === 1'b1) dcount++;
      end
      check("midreset no_done", dcount, 0);
      model_idle = 1'b1;
      run_cmd(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, model_lat(1'b1, 1'b1), 1'b0, 1, "after_reset");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
